// File: rtl/dout_collect_pkg.sv
// Shared types and default widths for the output collector.
package dout_collect_pkg;

  localparam int unsigned DataW         = 25;
  localparam int unsigned PeColNum      = 12;
  localparam int unsigned DoutFifoDepth = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCapt,
    StDrain,
    StFin
  } dout_state_e;

endpackage

// File: rtl/dout_vfifo.sv
// Row-vector FIFO with same-cycle push/pop; also exposes the entry behind the head.
module dout_vfifo #(
  parameter int unsigned Width = 300,
  parameter int unsigned Depth = 4,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [Width-1:0] rdata_nxt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      cnt_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt_ptr;
  logic [AW:0]      cnt_q;
  logic             wr_en, rd_en;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(Depth));
  assign cnt_o      = cnt_q;
  assign rd_en      = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en      = push_i && (!full_o || rd_en);
  assign rd_nxt_ptr = rd_ptr_q + AW'(1);

  assign rdata_o     = mem_q[rd_ptr_q];
  assign rdata_nxt_o = mem_q[rd_nxt_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_nxt_ptr;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dout_collect.sv
// Captures PE-array row vectors, buffers them and serializes enabled lanes to memory writes.
// DOUT_OVF_CNT_EN enables the saturating dropped-vector counter on ovf_cnt_o.
module dout_collect
  import dout_collect_pkg::*;
#(
  parameter int unsigned DATA_W     = DataW,
  parameter int unsigned PE_COL_NUM = PeColNum,
  parameter int unsigned FIFO_DEPTH = DoutFifoDepth,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [CNT_W-1:0]             delay_i,
  input  logic [CNT_W-1:0]             vec_num_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [PE_COL_NUM-1:0]        lane_mask_i,
  input  logic [DATA_W*PE_COL_NUM-1:0] in_row_i,
  output logic                         mem_req_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic                         mem_gnt_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         ovf_o,
  output logic [7:0]                   ovf_cnt_o
);

  localparam int unsigned VecW  = DATA_W * PE_COL_NUM;
  localparam int unsigned FcntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LaneW = $clog2(PE_COL_NUM);

  dout_state_e           state_q, state_d;
  logic [CNT_W-1:0]      dcnt_q, dcnt_d, vcnt_q, vcnt_d;
  logic [CNT_W-1:0]      delay_q, vec_q;
  logic [PE_COL_NUM-1:0] mask_q, rem_q, rem_d;
  logic                  last_q, last_d, req_q, req_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  start_ok, push, pop, drop, out_free, drained;
  logic                  fifo_full, fifo_empty;
  logic [FcntW-1:0]      fifo_cnt;
  logic [VecW-1:0]       fifo_head, fifo_nxt, src_vec;
  logic [PE_COL_NUM-1:0] src_rem, rem_after;
  logic                  src_vld;
  logic [LaneW-1:0]      lane;

  assign start_ok = start_i && (state_q == StIdle);
  assign push     = (state_q == StCapt);
  assign out_free = !req_q || mem_gnt_i;
  // Head leaves on the grant of its last word; an all-zero mask discards one vector per cycle.
  assign pop      = (mask_q == '0) ? !fifo_empty : (req_q && mem_gnt_i && last_q);
  assign drop     = push && fifo_full && !pop;

  dout_vfifo #(
    .Width(VecW),
    .Depth(FIFO_DEPTH)
  ) u_vfifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (in_row_i),
    .rdata_o    (fifo_head),
    .rdata_nxt_o(fifo_nxt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .cnt_o      (fifo_cnt)
  );

  // Serializer: pick the vector feeding the output register this cycle (head, the one
  // behind it when the head is leaving, or the incoming row when the FIFO is empty).
  always_comb begin
    src_vld = 1'b0;
    src_vec = fifo_head;
    src_rem = rem_q;
    if (mask_q != '0) begin
      if (pop) begin
        if (fifo_cnt >= FcntW'(2)) begin
          src_vld = 1'b1;
          src_vec = fifo_nxt;
          src_rem = mask_q;
        end else if (push) begin
          src_vld = 1'b1;
          src_vec = in_row_i;
          src_rem = mask_q;
        end
      end else if (!fifo_empty && (rem_q != '0)) begin
        src_vld = 1'b1;
      end else if (fifo_empty && push) begin
        src_vld = 1'b1;
        src_vec = in_row_i;
        src_rem = mask_q;
      end
    end

    lane = '0;
    for (int i = PE_COL_NUM - 1; i >= 0; i--) begin
      if (src_rem[i]) lane = LaneW'(i);
    end
    rem_after = src_rem & ~(PE_COL_NUM'(1) << lane);

    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    rem_d   = rem_q;
    last_d  = last_q;
    if (pop) begin
      rem_d  = mask_q;
      last_d = 1'b0;
    end
    if (out_free && src_vld) begin
      req_d   = 1'b1;
      addr_d  = waddr_q;
      waddr_d = waddr_q + ADDR_W'(1);
      wdata_d = src_vec[lane*DATA_W +: DATA_W];
      rem_d   = rem_after;
      last_d  = (rem_after == '0);
    end else if (out_free) begin
      req_d = 1'b0;
    end
    if (start_ok) begin
      rem_d   = lane_mask_i;
      waddr_d = base_addr_i;
      last_d  = 1'b0;
    end
    ovf_d = start_ok ? 1'b0 : (ovf_q | drop);
  end

  assign drained = (fifo_empty || (pop && (fifo_cnt == FcntW'(1)))) && !req_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          dcnt_d = CNT_W'(1);
          vcnt_d = '0;
          if (delay_i == '0) state_d = (vec_num_i == '0) ? StDrain : StCapt;
          else               state_d = StWait;
        end
      end
      StWait: begin
        if (dcnt_q == delay_q) state_d = (vec_q == '0) ? StDrain : StCapt;
        else                   dcnt_d = dcnt_q + CNT_W'(1);
      end
      StCapt: begin
        if (vcnt_q == vec_q - CNT_W'(1)) state_d = StDrain;
        else                             vcnt_d = vcnt_q + CNT_W'(1);
      end
      StDrain: begin
        if (drained) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dcnt_q  <= '0;
      vcnt_q  <= '0;
      delay_q <= '0;
      vec_q   <= '0;
      mask_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      vcnt_q  <= vcnt_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      ovf_q   <= ovf_d;
      if (start_ok) begin
        delay_q <= delay_i;
        vec_q   <= vec_num_i;
        mask_q  <= lane_mask_i;
      end
    end
  end

`ifdef DOUT_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_cnt_q <= 8'h00;
    end else if (start_ok) begin
      ovf_cnt_q <= 8'h00;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
`else
  assign ovf_cnt_o = 8'h00;
`endif

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StFin);
  assign ovf_o       = ovf_q;

endmodule
